// File: rtl/reorder_buffer_mc_if.sv
`default_nettype none
// ============================================================================
// Module   : reorder_buffer_mc_if
// Purpose  : Bundles the issue, operand lookup, writeback and commit signals
//            of the multi-commit reorder buffer.
// Revision : 1.0 - initial release
// ============================================================================
interface reorder_buffer_mc_if #(
    parameter int ROB_WIDTH    = 4,
    parameter int WB_PORTS     = 2,
    parameter int COMMIT_WIDTH = 2
) ();
    logic                              issue_signal;
    logic [1:0]                        issue_opcode;
    logic                              issue_value_ready;
    logic [31:0]                       issue_value;
    logic [31:0]                       issue_aux;
    logic [ROB_WIDTH-1:0]              rob_tag;
    logic                              full;
    logic [ROB_WIDTH:0]                count;
    logic [ROB_WIDTH-1:0]              rob_tag_rs1;
    logic [ROB_WIDTH-1:0]              rob_tag_rs2;
    logic                              rob_ready_rs1;
    logic                              rob_ready_rs2;
    logic [31:0]                       rob_value_rs1;
    logic [31:0]                       rob_value_rs2;
    logic [WB_PORTS-1:0]               wb_valid;
    logic [WB_PORTS*ROB_WIDTH-1:0]     wb_tag;
    logic [WB_PORTS*32-1:0]            wb_value;
    logic [COMMIT_WIDTH-1:0]           commit_reg_valid;
    logic [COMMIT_WIDTH*ROB_WIDTH-1:0] commit_reg_tag;
    logic [COMMIT_WIDTH*32-1:0]        commit_reg_value;
    logic                              commit_store_valid;
    logic [ROB_WIDTH-1:0]              commit_store_tag;
    logic                              predictor_signal;
    logic                              predictor_branch;
    logic                              clear_signal;
    logic [31:0]                       correct_pc;

    modport master (
        output issue_signal, issue_opcode, issue_value_ready, issue_value, issue_aux,
        output rob_tag_rs1, rob_tag_rs2, wb_valid, wb_tag, wb_value,
        input  rob_tag, full, count, rob_ready_rs1, rob_ready_rs2, rob_value_rs1, rob_value_rs2,
        input  commit_reg_valid, commit_reg_tag, commit_reg_value, commit_store_valid,
        input  commit_store_tag, predictor_signal, predictor_branch, clear_signal, correct_pc
    );

    modport slave (
        input  issue_signal, issue_opcode, issue_value_ready, issue_value, issue_aux,
        input  rob_tag_rs1, rob_tag_rs2, wb_valid, wb_tag, wb_value,
        output rob_tag, full, count, rob_ready_rs1, rob_ready_rs2, rob_value_rs1, rob_value_rs2,
        output commit_reg_valid, commit_reg_tag, commit_reg_value, commit_store_valid,
        output commit_store_tag, predictor_signal, predictor_branch, clear_signal, correct_pc
    );
endinterface
`default_nettype wire

// File: rtl/reorder_buffer_mc.sv
`default_nettype none
// ============================================================================
// Module   : reorder_buffer_mc
// Purpose  : Reorder buffer with one issue per cycle, several writeback
//            channels, in-order retirement of up to COMMIT_WIDTH entries per
//            cycle, same-cycle writeback forwarding and misprediction flush.
// Revision : 1.0 - initial release
// ============================================================================
module reorder_buffer_mc #(
    parameter int ROB_WIDTH    = 4,
    parameter int WB_PORTS     = 2,
    parameter int COMMIT_WIDTH = 2
) (
    input  wire logic          clk_in,
    input  wire logic          rst_in,
    input  wire logic          rdy_in,
    reorder_buffer_mc_if.slave bus
);
    localparam int         ROB_SIZE  = 2 ** ROB_WIDTH;
    localparam logic [1:0] OP_REG    = 2'b00;
    localparam logic [1:0] OP_STORE  = 2'b01;
    localparam logic [1:0] OP_BRANCH = 2'b10;

    // Entry storage
    logic [ROB_SIZE-1:0]  busy;
    logic [ROB_SIZE-1:0]  ready;
    logic [1:0]           opcode [ROB_SIZE];
    logic [31:0]          value  [ROB_SIZE];
    logic [31:0]          aux    [ROB_SIZE];
    logic [31:0]          res    [ROB_SIZE];
    logic [ROB_WIDTH-1:0] head;
    logic [ROB_WIDTH-1:0] tail;
    logic [ROB_WIDTH:0]   count;
    logic                 flush_pending;

    logic                                 full;
    logic                                 issue_fire;
    logic                                 fwd_enable;
    logic [WB_PORTS-1:0][ROB_WIDTH-1:0]   wb_tag_a;
    logic [1:0][ROB_WIDTH-1:0]            lk_tag;
    logic [1:0]                           lk_ready;
    logic [1:0][31:0]                     lk_value;

    // Commit-group decision for the current cycle
    logic [ROB_SIZE-1:0]                  commit_mask;
    logic [ROB_WIDTH:0]                   n_commit;
    logic [ROB_WIDTH-1:0]                 idx;
    logic                                 stop;
    logic                                 seen_store;
    logic [COMMIT_WIDTH-1:0]              nxt_reg_valid;
    logic [COMMIT_WIDTH*ROB_WIDTH-1:0]    nxt_reg_tag;
    logic [COMMIT_WIDTH*32-1:0]           nxt_reg_value;
    logic                                 nxt_store_valid;
    logic [ROB_WIDTH-1:0]                 nxt_store_tag;
    logic                                 nxt_pred_signal;
    logic                                 nxt_pred_branch;
    logic                                 nxt_clear;
    logic [31:0]                          nxt_correct_pc;

    // Registered commit outputs
    logic [COMMIT_WIDTH-1:0]              reg_valid_q;
    logic [COMMIT_WIDTH*ROB_WIDTH-1:0]    reg_tag_q;
    logic [COMMIT_WIDTH*32-1:0]           reg_value_q;
    logic                                 store_valid_q;
    logic [ROB_WIDTH-1:0]                 store_tag_q;
    logic                                 pred_signal_q;
    logic                                 pred_branch_q;
    logic                                 clear_q;
    logic [31:0]                          correct_pc_q;

    assign full       = (count == (ROB_WIDTH+1)'(ROB_SIZE));
    assign issue_fire = bus.issue_signal & ~full;
    assign fwd_enable = rdy_in & ~flush_pending;
    assign wb_tag_a   = bus.wb_tag;
    assign lk_tag[0]  = bus.rob_tag_rs1;
    assign lk_tag[1]  = bus.rob_tag_rs2;

    // Walk the head entries in order and stop at the first one that cannot retire
    always_comb begin
        commit_mask     = '0;
        n_commit        = '0;
        idx             = head;
        stop            = flush_pending;
        seen_store      = 1'b0;
        nxt_reg_valid   = '0;
        nxt_reg_tag     = '0;
        nxt_reg_value   = '0;
        nxt_store_valid = 1'b0;
        nxt_store_tag   = '0;
        nxt_pred_signal = 1'b0;
        nxt_pred_branch = 1'b0;
        nxt_clear       = 1'b0;
        nxt_correct_pc  = '0;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            idx = head + ROB_WIDTH'(k);
            if (!stop && busy[idx] && ready[idx] && !(opcode[idx] == OP_STORE && seen_store)) begin
                commit_mask[idx] = 1'b1;
                n_commit         = n_commit + (ROB_WIDTH+1)'(1);
                case (opcode[idx])
                    OP_REG: begin
                        nxt_reg_valid[k]                         = 1'b1;
                        nxt_reg_tag[k*ROB_WIDTH +: ROB_WIDTH]    = idx;
                        nxt_reg_value[k*32 +: 32]                = value[idx];
                    end
                    OP_STORE: begin
                        nxt_store_valid = 1'b1;
                        nxt_store_tag   = idx;
                        seen_store      = 1'b1;
                    end
                    OP_BRANCH: begin
                        nxt_pred_signal = 1'b1;
                        nxt_pred_branch = res[idx][0];
                        stop            = 1'b1;
                        if (aux[idx][1] != res[idx][0]) begin
                            nxt_clear      = 1'b1;
                            nxt_correct_pc = {aux[idx][31:2], 2'b00};
                        end
                    end
                    default: begin
                        // JALR writes its link value like a REG and checks the target
                        nxt_reg_valid[k]                         = 1'b1;
                        nxt_reg_tag[k*ROB_WIDTH +: ROB_WIDTH]    = idx;
                        nxt_reg_value[k*32 +: 32]                = value[idx];
                        stop                                     = 1'b1;
                        if (res[idx] != aux[idx]) begin
                            nxt_clear      = 1'b1;
                            nxt_correct_pc = res[idx];
                        end
                    end
                endcase
            end else begin
                stop = 1'b1;
            end
        end
    end

    // Operand lookup with forwarding of same-cycle writebacks to REG/STORE entries
    always_comb begin
        lk_ready = '0;
        lk_value = '0;
        for (int j = 0; j < 2; j++) begin
            lk_ready[j] = busy[lk_tag[j]] & ready[lk_tag[j]];
            lk_value[j] = value[lk_tag[j]];
            if (fwd_enable && busy[lk_tag[j]] &&
                (opcode[lk_tag[j]] == OP_REG || opcode[lk_tag[j]] == OP_STORE)) begin
                for (int k = 0; k < WB_PORTS; k++) begin
                    if (bus.wb_valid[k] && wb_tag_a[k] == lk_tag[j]) begin
                        lk_ready[j] = 1'b1;
                        lk_value[j] = bus.wb_value[k*32 +: 32];
                    end
                end
            end
        end
    end

    // Control state: occupancy, pointers and the one-cycle-delayed flush
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy          <= '0;
            ready         <= '0;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            flush_pending <= 1'b0;
        end else if (rdy_in) begin
            if (flush_pending) begin
                busy          <= '0;
                ready         <= '0;
                head          <= '0;
                tail          <= '0;
                count         <= '0;
                flush_pending <= 1'b0;
            end else begin
                for (int k = 0; k < WB_PORTS; k++) begin
                    if (bus.wb_valid[k] && busy[wb_tag_a[k]]) begin
                        ready[wb_tag_a[k]] <= 1'b1;
                    end
                end
                for (int i = 0; i < ROB_SIZE; i++) begin
                    if (commit_mask[i]) begin
                        busy[i] <= 1'b0;
                    end
                end
                if (issue_fire) begin
                    busy[tail]  <= 1'b1;
                    ready[tail] <= bus.issue_value_ready;
                    tail        <= tail + ROB_WIDTH'(1);
                end
                head          <= head + n_commit[ROB_WIDTH-1:0];
                count         <= count + (ROB_WIDTH+1)'(issue_fire) - n_commit;
                flush_pending <= nxt_clear;
            end
        end
    end

    // Entry payload: writeback results and newly issued instructions
    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && !flush_pending) begin
            for (int k = 0; k < WB_PORTS; k++) begin
                if (bus.wb_valid[k] && busy[wb_tag_a[k]]) begin
                    case (opcode[wb_tag_a[k]])
                        OP_REG, OP_STORE: value[wb_tag_a[k]]  <= bus.wb_value[k*32 +: 32];
                        OP_BRANCH:        res[wb_tag_a[k]][0] <= bus.wb_value[k*32];
                        default:          res[wb_tag_a[k]]    <= bus.wb_value[k*32 +: 32];
                    endcase
                end
            end
            if (issue_fire) begin
                opcode[tail] <= bus.issue_opcode;
                value[tail]  <= bus.issue_value;
                aux[tail]    <= bus.issue_aux;
                res[tail]    <= '0;
            end
        end
    end

    // Commit outputs; pulses drop to zero while paused, payload is held
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            reg_valid_q   <= '0;
            reg_tag_q     <= '0;
            reg_value_q   <= '0;
            store_valid_q <= 1'b0;
            store_tag_q   <= '0;
            pred_signal_q <= 1'b0;
            pred_branch_q <= 1'b0;
            clear_q       <= 1'b0;
            correct_pc_q  <= '0;
        end else if (!rdy_in) begin
            reg_valid_q   <= '0;
            store_valid_q <= 1'b0;
            pred_signal_q <= 1'b0;
            clear_q       <= 1'b0;
        end else begin
            reg_valid_q   <= nxt_reg_valid;
            reg_tag_q     <= nxt_reg_tag;
            reg_value_q   <= nxt_reg_value;
            store_valid_q <= nxt_store_valid;
            store_tag_q   <= nxt_store_tag;
            pred_signal_q <= nxt_pred_signal;
            pred_branch_q <= nxt_pred_branch;
            clear_q       <= nxt_clear;
            correct_pc_q  <= nxt_correct_pc;
        end
    end

    assign bus.rob_tag            = tail;
    assign bus.full               = full;
    assign bus.count              = count;
    assign bus.rob_ready_rs1      = lk_ready[0];
    assign bus.rob_ready_rs2      = lk_ready[1];
    assign bus.rob_value_rs1      = lk_value[0];
    assign bus.rob_value_rs2      = lk_value[1];
    assign bus.commit_reg_valid   = reg_valid_q;
    assign bus.commit_reg_tag     = reg_tag_q;
    assign bus.commit_reg_value   = reg_value_q;
    assign bus.commit_store_valid = store_valid_q;
    assign bus.commit_store_tag   = store_tag_q;
    assign bus.predictor_signal   = pred_signal_q;
    assign bus.predictor_branch   = pred_branch_q;
    assign bus.clear_signal       = clear_q;
    assign bus.correct_pc         = correct_pc_q;
endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_reorder_buffer_mc
// Purpose  : Self-checking bench for reorder_buffer_mc: directed scenarios
//            followed by randomized traffic against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reorder_buffer_mc;
    localparam int RW   = 4;
    localparam int SIZE = 16;
    localparam int WBP  = 2;
    localparam int CW   = 2;
    localparam logic [1:0] OP_REG = 2'b00, OP_ST = 2'b01, OP_BR = 2'b10, OP_JALR = 2'b11;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 0;

    reorder_buffer_mc_if #(.ROB_WIDTH(RW), .WB_PORTS(WBP), .COMMIT_WIDTH(CW)) bus ();

    reorder_buffer_mc #(.ROB_WIDTH(RW), .WB_PORTS(WBP), .COMMIT_WIDTH(CW)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    // ---------------- behavioural model: in-order queue of live entries ----
    typedef struct packed {
        logic [1:0]  op;
        logic        rdy;
        logic [31:0] value;
        logic [31:0] aux;
        logic [31:0] res;
    } ent_t;

    ent_t              q[$];
    int                m_head = 0;
    bit                m_pend = 0;
    logic [CW-1:0]     e_regv;
    logic [CW-1:0][3:0]  e_regt;
    logic [CW-1:0][31:0] e_regval;
    logic              e_stv;
    logic [3:0]        e_stt;
    logic              e_ps, e_pb, e_clr;
    logic [31:0]       e_pc;
    ent_t              me;
    int                n_ret, old_n, wt, pos;
    bit                halt, store_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk_in) begin
        if (rst_in) begin
            q.delete(); m_head = 0; m_pend = 0;
            e_regv = '0; e_stv = 0; e_ps = 0; e_clr = 0;
        end else if (!rdy_in) begin
            e_regv = '0; e_stv = 0; e_ps = 0; e_clr = 0;
        end else if (m_pend) begin
            q.delete(); m_head = 0; m_pend = 0;
            e_regv = '0; e_stv = 0; e_ps = 0; e_clr = 0;
        end else begin
            e_regv = '0; e_stv = 0; e_ps = 0; e_clr = 0;
            n_ret = 0; halt = 0; store_seen = 0;
            for (int k = 0; k < CW; k++) begin
                if (!halt && k < q.size()) begin
                    me = q[k];
                    if (!me.rdy || (me.op == OP_ST && store_seen)) halt = 1;
                    else begin
                        n_ret++;
                        case (me.op)
                            OP_REG: begin e_regv[k] = 1; e_regt[k] = 4'((m_head + k) % SIZE); e_regval[k] = me.value; end
                            OP_ST:  begin e_stv = 1; e_stt = 4'((m_head + k) % SIZE); store_seen = 1; end
                            OP_BR: begin
                                e_ps = 1; e_pb = me.res[0]; halt = 1;
                                if (me.aux[1] != me.res[0]) begin e_clr = 1; e_pc = {me.aux[31:2], 2'b00}; end
                            end
                            default: begin
                                e_regv[k] = 1; e_regt[k] = 4'((m_head + k) % SIZE); e_regval[k] = me.value; halt = 1;
                                if (me.res != me.aux) begin e_clr = 1; e_pc = me.res; end
                            end
                        endcase
                    end
                end
            end
            for (int k = 0; k < WBP; k++) begin
                if (bus.wb_valid[k]) begin
                    wt  = int'(bus.wb_tag[k*RW +: RW]);
                    pos = (wt - m_head + SIZE) % SIZE;
                    if (pos < q.size()) begin
                        me = q[pos];
                        me.rdy = 1;
                        if (me.op == OP_REG || me.op == OP_ST) me.value = bus.wb_value[k*32 +: 32];
                        else if (me.op == OP_BR) me.res[0] = bus.wb_value[k*32];
                        else me.res = bus.wb_value[k*32 +: 32];
                        q[pos] = me;
                    end
                end
            end
            old_n = q.size();
            repeat (n_ret) void'(q.pop_front());
            m_head = (m_head + n_ret) % SIZE;
            if (bus.issue_signal && old_n < SIZE)
                q.push_back('{bus.issue_opcode, bus.issue_value_ready, bus.issue_value, bus.issue_aux, 32'h0});
            m_pend = e_clr;
        end
    end

    // Expected operand lookup result for one tag
    function automatic logic [32:0] exp_lookup(input logic [3:0] t);
        int p;
        logic r;
        logic [31:0] v;
        p = (int'(t) - m_head + SIZE) % SIZE;
        r = 0; v = 0;
        if (p < q.size()) begin
            r = q[p].rdy; v = q[p].value;
            if (rdy_in && !m_pend && (q[p].op == OP_REG || q[p].op == OP_ST)) begin
                for (int k = 0; k < WBP; k++)
                    if (bus.wb_valid[k] && bus.wb_tag[k*RW +: RW] == t) begin r = 1; v = bus.wb_value[k*32 +: 32]; end
            end
        end
        return {r, v};
    endfunction

    // Compare process: every output against the model once per cycle
    always @(negedge clk_in) begin
        if (chk_en) begin
            logic [32:0] l1, l2;
            check("count", 32'(bus.count), 32'(q.size()));
            check("full", 32'(bus.full), 32'(q.size() == SIZE));
            check("rob_tag", 32'(bus.rob_tag), 32'((m_head + q.size()) % SIZE));
            check("reg_valid", 32'(bus.commit_reg_valid), 32'(e_regv));
            for (int k = 0; k < CW; k++) begin
                if (e_regv[k]) begin
                    check($sformatf("reg_tag%0d", k), 32'(bus.commit_reg_tag[k*RW +: RW]), 32'(e_regt[k]));
                    check($sformatf("reg_value%0d", k), bus.commit_reg_value[k*32 +: 32], e_regval[k]);
                end
            end
            check("store_valid", 32'(bus.commit_store_valid), 32'(e_stv));
            if (e_stv) check("store_tag", 32'(bus.commit_store_tag), 32'(e_stt));
            check("predictor_signal", 32'(bus.predictor_signal), 32'(e_ps));
            if (e_ps) check("predictor_branch", 32'(bus.predictor_branch), 32'(e_pb));
            check("clear_signal", 32'(bus.clear_signal), 32'(e_clr));
            if (e_clr) check("correct_pc", bus.correct_pc, e_pc);
            l1 = exp_lookup(bus.rob_tag_rs1);
            l2 = exp_lookup(bus.rob_tag_rs2);
            check("ready_rs1", 32'(bus.rob_ready_rs1), 32'(l1[32]));
            check("ready_rs2", 32'(bus.rob_ready_rs2), 32'(l2[32]));
            if (l1[32]) check("value_rs1", bus.rob_value_rs1, l1[31:0]);
            if (l2[32]) check("value_rs2", bus.rob_value_rs2, l2[31:0]);
        end
    end

    // ---------------- stimulus helpers -------------------------------------
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        rdy_in = 1; rst_in = 0;
        bus.issue_signal = 0; bus.issue_opcode = 0; bus.issue_value_ready = 0;
        bus.issue_value = 0; bus.issue_aux = 0;
        bus.wb_valid = '0; bus.wb_tag = '0; bus.wb_value = '0;
        bus.rob_tag_rs1 = 0; bus.rob_tag_rs2 = 0;
    endtask

    task automatic do_reset();
        idle(); rst_in = 1; step(); rst_in = 0;
    endtask

    task automatic set_issue(input logic [1:0] op, input logic rdy, input logic [31:0] val, input logic [31:0] ax);
        bus.issue_signal = 1; bus.issue_opcode = op; bus.issue_value_ready = rdy;
        bus.issue_value = val; bus.issue_aux = ax;
    endtask

    task automatic set_wb(input int ch, input logic [3:0] tag, input logic [31:0] val);
        bus.wb_valid[ch] = 1; bus.wb_tag[ch*RW +: RW] = tag; bus.wb_value[ch*32 +: 32] = val;
    endtask

    int mode, iss_pct, wb_pct, ctl, r, p;
    logic [1:0] op;

    initial begin
        idle(); rst_in = 1;
        step(); step();
        chk_en = 1; rst_in = 0;
        check("lit_reset_count", 32'(bus.count), 32'd0);
        check("lit_reset_clear", 32'(bus.clear_signal), 32'd0);

        // Fill: tag 0 not ready blocks retirement, 17th issue is ignored
        for (int i = 0; i < 17; i++) begin
            set_issue(OP_REG, i != 0, 32'h1000 + i, 0);
            step();
            if (i == 15) begin
                check("lit_full16", 32'(bus.full), 32'd1);
                check("lit_count16", 32'(bus.count), 32'd16);
            end
        end
        check("lit_count_after_17th", 32'(bus.count), 32'd16);
        idle(); set_wb(0, 4'd0, 32'hA5A5_0000); step();
        idle(); step();
        check("lit_retire01_valid", 32'(bus.commit_reg_valid), 32'h3);
        check("lit_retire01_tags", 32'(bus.commit_reg_tag), 32'h10);
        check("lit_retire1_value", bus.commit_reg_value[63:32], 32'h1001);
        step();
        check("lit_retire23_tags", 32'(bus.commit_reg_tag), 32'h32);
        repeat (6) step();
        check("lit_drained", 32'(bus.count), 32'd0);

        // Same-cycle forwarding
        do_reset();
        set_issue(OP_REG, 0, 0, 0); step();
        idle(); set_wb(1, 4'd0, 32'hDEADBEEF); set_wb(0, 4'd5, 32'h0); bus.rob_tag_rs1 = 0;
        #2;
        check("lit_fwd_ready", 32'(bus.rob_ready_rs1), 32'd1);
        check("lit_fwd_value", bus.rob_value_rs1, 32'hDEADBEEF);
        step(); idle(); step();
        check("lit_fwd_commit_valid", 32'(bus.commit_reg_valid[0]), 32'd1);
        check("lit_fwd_commit_value", bus.commit_reg_value[31:0], 32'hDEADBEEF);

        // One store per commit group
        do_reset();
        set_issue(OP_ST, 0, 0, 0); step();
        set_issue(OP_ST, 1, 0, 0); step();
        set_issue(OP_REG, 1, 32'h77, 0); step();
        idle(); set_wb(0, 4'd0, 32'h0); step();
        idle(); step();
        check("lit_st0_valid", 32'(bus.commit_store_valid), 32'd1);
        check("lit_st0_tag", 32'(bus.commit_store_tag), 32'd0);
        check("lit_st0_reg", 32'(bus.commit_reg_valid), 32'd0);
        step();
        check("lit_st1_tag", 32'(bus.commit_store_tag), 32'd1);
        check("lit_st1_reg", 32'(bus.commit_reg_valid), 32'h2);
        check("lit_st1_regtag", 32'(bus.commit_reg_tag[7:4]), 32'd2);

        // Branch misprediction and flush
        do_reset();
        set_issue(OP_BR, 0, 0, 32'h0000_1004); step();
        set_issue(OP_REG, 1, 32'h55, 0); step();
        idle(); set_wb(0, 4'd0, 32'h1); step();
        idle(); step();
        check("lit_br_pred", 32'(bus.predictor_signal), 32'd1);
        check("lit_br_taken", 32'(bus.predictor_branch), 32'd1);
        check("lit_br_clear", 32'(bus.clear_signal), 32'd1);
        check("lit_br_pc", bus.correct_pc, 32'h0000_1004);
        step();
        check("lit_br_flushed", 32'(bus.count), 32'd0);
        check("lit_br_noreg", 32'(bus.commit_reg_valid), 32'd0);

        // JALR predicted correctly, then mispredicted
        do_reset();
        set_issue(OP_JALR, 0, 32'h208, 32'h300); step();
        idle(); set_wb(0, 4'd0, 32'h300); step();
        idle(); step();
        check("lit_jalr_ok_value", bus.commit_reg_value[31:0], 32'h208);
        check("lit_jalr_ok_clear", 32'(bus.clear_signal), 32'd0);
        step();
        set_issue(OP_JALR, 0, 32'h208, 32'h300); step();
        idle(); set_wb(1, 4'd1, 32'h340); step();
        idle(); step();
        check("lit_jalr_bad_clear", 32'(bus.clear_signal), 32'd1);
        check("lit_jalr_bad_pc", bus.correct_pc, 32'h340);
        step();

        // Pause with issue and writeback active
        do_reset();
        set_issue(OP_REG, 1, 32'h11, 0); step();
        set_issue(OP_REG, 0, 32'h22, 0); step();
        rdy_in = 0; set_wb(0, 4'd1, 32'h99);
        for (int i = 0; i < 3; i++) begin
            step();
            check("lit_pause_count", 32'(bus.count), 32'd1);
            check("lit_pause_regv", 32'(bus.commit_reg_valid), 32'd0);
            check("lit_pause_clear", 32'(bus.clear_signal), 32'd0);
        end
        idle(); step();

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            mode    = (c / 400) % 3;
            iss_pct = (mode == 0) ? 90 : (mode == 1) ? 60 : 30;
            wb_pct  = (mode == 0) ? 15 : (mode == 1) ? 60 : 90;
            ctl     = (mode == 0) ? 1 : 4;
            idle();
            rdy_in = ($urandom_range(0, 15) != 0);
            rst_in = ($urandom_range(0, 799) == 0);
            if ($urandom_range(0, 99) < iss_pct) begin
                r = $urandom_range(0, 31);
                if (r < ctl) op = (r % 2 == 0) ? OP_BR : OP_JALR;
                else if (r < ctl + 8) op = OP_ST;
                else op = OP_REG;
                set_issue(op, $urandom_range(0, 2) == 0, $urandom, (op == OP_BR) ? ($urandom & 32'hFFFF_FFFE) : $urandom);
            end
            for (int ch = 0; ch < WBP; ch++) begin
                if ($urandom_range(0, 99) < wb_pct) begin
                    p = $urandom_range(0, q.size() + 1);
                    if (!(ch == 1 && bus.wb_valid[0] && bus.wb_tag[3:0] == 4'((m_head + p) % SIZE))) begin
                        if (p < q.size() && q[p].op == OP_JALR && $urandom_range(0, 1) == 1)
                            set_wb(ch, 4'((m_head + p) % SIZE), q[p].aux);
                        else
                            set_wb(ch, 4'((m_head + p) % SIZE), $urandom);
                    end
                end
            end
            bus.rob_tag_rs1 = $urandom_range(0, 1) ? bus.wb_tag[3:0] : 4'($urandom);
            bus.rob_tag_rs2 = $urandom_range(0, 1) ? bus.wb_tag[7:4] : 4'($urandom);
            step();
        end
        idle();
        repeat (20) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
